// File: rtl/cook_pkg.sv
// Shared types and limits for the cook-time countdown: state encoding, BCD digit bounds,
// MM:SS time struct and the load-validation helper.
package cook_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        return (t.min_tens <= BCD_MAX_DIGIT) && (t.min_ones <= BCD_MAX_DIGIT) &&
               (t.sec_tens <= BCD_MAX_SEC_TENS) && (t.sec_ones <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/cook_countdown_if.sv
// Keypad-side digit/command inputs and display/magnetron/beeper-side outputs of the countdown.
// master = driver of commands (keypad side), slave = the countdown block.
interface cook_countdown_if;
    logic       load;
    logic [3:0] min_tens_in;
    logic [3:0] min_ones_in;
    logic [3:0] sec_tens_in;
    logic [3:0] sec_ones_in;
    logic       start;
    logic       stop;
    logic       door_open;

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       paused;
    logic       done;
    logic       beep;
    logic       load_err;

    modport master (
        output load, min_tens_in, min_ones_in, sec_tens_in, sec_ones_in, start, stop, door_open,
        input  min_tens, min_ones, sec_tens, sec_ones, running, paused, done, beep, load_err
    );

    modport slave (
        input  load, min_tens_in, min_ones_in, sec_tens_in, sec_ones_in, start, stop, door_open,
        output min_tens, min_ones, sec_tens, sec_ones, running, paused, done, beep, load_err
    );
endinterface

// File: rtl/bcd_time_decrement.sv
// Combinational MM:SS BCD minus one second with borrow chain; 00:00 saturates (no wrap).
// is_zero flags that the result is 00:00.
module bcd_time_decrement
    import cook_pkg::*;
(
    input  bcd_time_t cur,
    output bcd_time_t nxt,
    output logic      is_zero
);

    always_comb begin
        nxt = cur;
        if (cur == '0) begin
            nxt = cur;
        end else if (cur.sec_ones != 4'd0) begin
            nxt.sec_ones = cur.sec_ones - 4'd1;
        end else begin
            nxt.sec_ones = BCD_MAX_DIGIT;
            if (cur.sec_tens != 4'd0) begin
                nxt.sec_tens = cur.sec_tens - 4'd1;
            end else begin
                nxt.sec_tens = BCD_MAX_SEC_TENS;
                if (cur.min_ones != 4'd0) begin
                    nxt.min_ones = cur.min_ones - 4'd1;
                end else begin
                    nxt.min_ones = BCD_MAX_DIGIT;
                    nxt.min_tens = cur.min_tens - 4'd1;
                end
            end
        end
        is_zero = (nxt == '0);
    end

endmodule

// File: rtl/cook_countdown.sv
// Microwave cook-time countdown: IDLE/RUNNING/PAUSED/DONE FSM over a BCD MM:SS register,
// one decrement per clk_1s edge, beep held DONE_HOLD cycles at completion. All outputs registered.
module cook_countdown
    import cook_pkg::*;
#(
    parameter int DONE_HOLD = 3
) (
    input  logic                   clk_1s,
    input  logic                   reset,
    cook_countdown_if.slave        bus
);

    localparam int HOLD_W = $clog2(DONE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DONE_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t            state;
    bcd_time_t         tm;
    bcd_time_t         tm_dec;
    bcd_time_t         din;
    logic              dec_zero;
    logic [HOLD_W-1:0] hold;
    logic              running;
    logic              paused;
    logic              done;
    logic              beep;
    logic              load_err;

    assign din = '{min_tens: bus.min_tens_in, min_ones: bus.min_ones_in,
                   sec_tens: bus.sec_tens_in, sec_ones: bus.sec_ones_in};

    bcd_time_decrement u_dec (
        .cur     (tm),
        .nxt     (tm_dec),
        .is_zero (dec_zero)
    );

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tm       <= '0;
            hold     <= '0;
            running  <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
            beep     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    // load wins over start on the same edge
                    if (bus.load) begin
                        if (bcd_time_valid(din)) tm <= din;
                        else                     load_err <= 1'b1;
                    end else if (bus.start && !bus.door_open && (tm != '0)) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (bus.stop || bus.door_open) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                        paused  <= 1'b1;
                    end else begin
                        tm <= tm_dec;
                        if (dec_zero) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            beep    <= 1'b1;
                            hold    <= HOLD_LOAD;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        paused <= 1'b0;
                        tm     <= '0;
                    end else if (bus.start && !bus.door_open) begin
                        state   <= RUNNING;
                        paused  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.stop || (hold <= HOLD_ONE)) begin
                        state <= IDLE;
                        beep  <= 1'b0;
                        hold  <= '0;
                        tm    <= '0;
                    end else begin
                        hold <= hold - HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.min_tens = tm.min_tens;
    assign bus.min_ones = tm.min_ones;
    assign bus.sec_tens = tm.sec_tens;
    assign bus.sec_ones = tm.sec_ones;
    assign bus.running  = running;
    assign bus.paused   = paused;
    assign bus.done     = done;
    assign bus.beep     = beep;
    assign bus.load_err = load_err;

endmodule
